// File: rtl/nibbler_disp_scan.sv
// Nibbler CPU 4-digit multiplexed common-anode 7-segment display scanner.
// Define NIBBLER_FLAGS_DP_EN to show CARRY/ZERO on the decimal points of digits 0/1.
module nibbler_disp_scan #(
  parameter int SCAN_DIV  = 1024,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] OUT_0,
  input  logic [3:0] OUT_1,
  input  logic [3:0] OUT_2,
  input  logic [3:0] A,
  input  logic       CARRY,
  input  logic       ZERO,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] C_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYC);

  generate
    if (SCAN_DIV < 2 || BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_bad_params
      $error("nibbler_disp_scan: need SCAN_DIV >= 2 and 0 <= BLANK_CYC < SCAN_DIV");
    end
  endgenerate

  typedef enum logic {INIT, SCAN} state_t;

  state_t        state, state_next;
  logic [CW-1:0] c, c_next;
  logic [1:0]    d, d_next;
  logic          capture;
  logic          cap_flag;
  logic [3:0]    snap_a, snap_o0, snap_o1, snap_o2;
  logic          lit;
  logic [3:0]    digit_val;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    c_next     = c;
    d_next     = d;
    capture    = 1'b0;
    case (state)
      INIT: begin
        capture    = 1'b1;
        c_next     = '0;
        d_next     = 2'd0;
        state_next = SCAN;
      end
      default: begin
        if (c == C_LAST) begin
          c_next  = '0;
          d_next  = d + 2'd1;
          capture = (d == 2'd3);
        end else begin
          c_next = c + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c       <= '0;
      d       <= 2'd0;
      snap_a  <= 4'h0;
      snap_o0 <= 4'h0;
      snap_o1 <= 4'h0;
      snap_o2 <= 4'h0;
    end else begin
      c <= c_next;
      d <= d_next;
      if (capture) begin
        snap_a  <= A;
        snap_o0 <= OUT_0;
        snap_o1 <= OUT_1;
        snap_o2 <= OUT_2;
      end
    end
  end

`ifdef NIBBLER_FLAGS_DP_EN
  logic snap_carry, snap_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_carry <= 1'b0;
      snap_zero  <= 1'b0;
    end else if (capture) begin
      snap_carry <= CARRY;
      snap_zero  <= ZERO;
    end
  end

  always_comb begin
    dp_next = 1'b1;
    if (lit && ((d == 2'd0 && snap_carry) || (d == 2'd1 && snap_zero))) begin
      dp_next = 1'b0;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = CARRY ^ ZERO;
  assign dp_next      = 1'b1;
`endif

  // Anodes stay dark during INIT and the first BLANK_CYC cycles of each digit period.
  always_comb begin
    lit       = (state == SCAN) && (c >= C_BLANK);
    digit_val = snap_a;
    case (d)
      2'd0:    digit_val = snap_a;
      2'd1:    digit_val = snap_o0;
      2'd2:    digit_val = snap_o1;
      default: digit_val = snap_o2;
    endcase
    seg_next = hex7(digit_val);
    an_next  = 4'b1111;
    if (lit) begin
      an_next[d] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      cap_flag   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_next;
      dp         <= dp_next;
      cap_flag   <= capture;
      frame_tick <= cap_flag;
      if (lit) begin
        seg <= seg_next;
      end
    end
  end

endmodule

// File: tb/tb_nibbler_disp_scan.sv
// Self-checking bench for nibbler_disp_scan (SCAN_DIV=8, BLANK_CYC=2) against an edge-count model.
module tb_nibbler_disp_scan;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * SD;
`ifdef NIBBLER_FLAGS_DP_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] out_0, out_1, out_2, a_in;
  logic       carry, zero;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibbler_disp_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .reset(reset),
    .OUT_0(out_0), .OUT_1(out_1), .OUT_2(out_2), .A(a_in),
    .CARRY(carry), .ZERO(zero),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] a, o0, o1, o2, input logic cy, zr);
    a_in  = a;
    out_0 = o0;
    out_1 = o1;
    out_2 = o2;
    carry = cy;
    zero  = zr;
  endtask

  // Model: k counts edges since reset release; the whole display is a function of k and the last capture.
  bit         model_on = 1'b0;
  int         k, p, dig, cc;
  logic [3:0] msnap [4];
  logic       msnap_c, msnap_z;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp, exp_ft;

  task automatic check_output();
    cmp("an", {4'h0, an}, {4'h0, exp_an});
    cmp("seg", {1'b0, seg}, {1'b0, exp_seg});
    cmp("dp", {7'h0, dp}, {7'h0, exp_dp});
    cmp("frame_tick", {7'h0, frame_tick}, {7'h0, exp_ft});
    cmp("one_anode", {7'h0, ($countones(~an) <= 1)}, 8'h01);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      model_on = 1'b1;
      k        = 0;
      exp_an   = 4'hF;
      exp_seg  = 7'h7F;
      exp_dp   = 1'b1;
      exp_ft   = 1'b0;
      for (int i = 0; i < 4; i++) msnap[i] = 4'h0;
      msnap_c  = 1'b0;
      msnap_z  = 1'b0;
    end else if (model_on) begin
      k++;
      exp_an = 4'hF;
      exp_dp = 1'b1;
      exp_ft = 1'b0;
      if (k >= 2) begin
        p      = (k - 2) % FR;
        dig    = p / SD;
        cc     = p % SD;
        exp_ft = (p == 0);
        if (cc >= BC) begin
          exp_an[dig] = 1'b0;
          exp_seg     = HEX[msnap[dig]];
          if (DP_EN && ((dig == 0 && msnap_c) || (dig == 1 && msnap_z))) exp_dp = 1'b0;
        end
      end
      if ((k - 1) % FR == 0) begin
        msnap[0] = a_in;
        msnap[1] = out_0;
        msnap[2] = out_1;
        msnap[3] = out_2;
        msnap_c  = carry;
        msnap_z  = zero;
      end
    end
    #1;
    if (model_on) check_output();
  end

  initial begin
    reset = 1'b1;
    apply_stimulus(4'h0, 4'hC, 4'h6, 4'h8, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Fixed first scenario, with literal pins at the edges the timing rules name.
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #2;
      case (i)
        1:  cmp("e1_an", {4'h0, an}, 8'h0F);
        2:  begin
              cmp("e2_tick", {7'h0, frame_tick}, 8'h01);
              cmp("e2_seg", {1'b0, seg}, 8'h7F);
              cmp("e2_an", {4'h0, an}, 8'h0F);
            end
        3:  cmp("e3_an", {4'h0, an}, 8'h0F);
        4:  begin
              cmp("e4_an", {4'h0, an}, 8'h0E);
              cmp("e4_seg", {1'b0, seg}, 8'h40);
              cmp("e4_dp", {7'h0, dp}, {7'h0, !DP_EN});
            end
        9:  cmp("e9_an", {4'h0, an}, 8'h0E);
        10: begin
              cmp("e10_an", {4'h0, an}, 8'h0F);
              cmp("e10_seg", {1'b0, seg}, 8'h40);
            end
        12: begin
              cmp("e12_an", {4'h0, an}, 8'h0D);
              cmp("e12_seg", {1'b0, seg}, 8'h46);
              cmp("e12_dp", {7'h0, dp}, 8'h01);
            end
        20: begin
              cmp("e20_an", {4'h0, an}, 8'h0B);
              cmp("e20_seg", {1'b0, seg}, 8'h02);
            end
        28: begin
              cmp("e28_an", {4'h0, an}, 8'h07);
              cmp("e28_seg", {1'b0, seg}, 8'h00);
            end
        33: cmp("e33_tick", {7'h0, frame_tick}, 8'h00);
        34: cmp("e34_tick", {7'h0, frame_tick}, 8'h01);
        52: begin
              cmp("e52_an", {4'h0, an}, 8'h0B);
              cmp("e52_seg", {1'b0, seg}, 8'h0E);
            end
        default: ;
      endcase
      if (i == 11) begin
        @(negedge clk) out_1 = 4'hF;
      end
    end

    // Mid-frame reset pulse, then a restart with ZERO set instead of CARRY.
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(4'h0, 4'hC, 4'hF, 4'h8, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    cmp("rst_an", {4'h0, an}, 8'h0F);
    cmp("rst_seg", {1'b0, seg}, 8'h7F);
    cmp("rst_dp", {7'h0, dp}, 8'h01);
    cmp("rst_tick", {7'h0, frame_tick}, 8'h00);
    @(negedge clk) reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #2;
      case (i)
        2:  cmp("r2_tick", {7'h0, frame_tick}, 8'h01);
        4:  begin
              cmp("r4_an", {4'h0, an}, 8'h0E);
              cmp("r4_seg", {1'b0, seg}, 8'h40);
              cmp("r4_dp", {7'h0, dp}, 8'h01);
            end
        12: begin
              cmp("r12_an", {4'h0, an}, 8'h0D);
              cmp("r12_dp", {7'h0, dp}, {7'h0, !DP_EN});
            end
        default: ;
      endcase
    end

    // Random inputs every cycle with occasional reset pulses; the model checks every edge.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      apply_stimulus(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                     1'($urandom), 1'($urandom));
      reset = ($urandom_range(0, 249) == 0);
    end
    @(negedge clk) reset = 1'b0;
    repeat (40) @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
